rvvi_replay_list: RTL and testbench



---
 rtl/rvvi_pkg.sv | 12 +
 rtl/rvvi_tag_match.sv | 26 ++
 rtl/rvvi_replay_list.sv | 185 ++++++++++++++++++
 tb/tb_rvvi_replay_list.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rvvi_pkg.sv
// Shared types and constants for the RVVI replay list and its tag CAM.
package rvvi_pkg;

  localparam int RVVI_FRAME_COUNT_WIDTH = 16;

  typedef enum logic [1:0] {
    RL_IDLE,
    RL_REPLAY,
    RL_WAIT
  } rl_state_t;

endpackage

// File: rtl/rvvi_tag_match.sv
// Tag CAM: compares a key against every active tag and reports the lowest matching index.
module rvvi_tag_match #(
  parameter int ENTRIES   = 8,
  parameter int TAG_WIDTH = 16,
  parameter int IDX_WIDTH = 3
) (
  input  logic [TAG_WIDTH-1:0] tags [ENTRIES],
  input  logic [ENTRIES-1:0]   active,
  input  logic [TAG_WIDTH-1:0] key,
  output logic                 hit,
  output logic [IDX_WIDTH-1:0] idx
);

  // Scan from the top down so the lowest matching index is the one left standing.
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (active[i] && (tags[i] == key)) begin
        hit = 1'b1;
        idx = IDX_WIDTH'(i);
      end
    end
  end

endmodule

// File: rtl/rvvi_replay_list.sv
// Circular record of transmitted RVVI frames with ack retirement and oldest-first replay.
// Optional ack timeout replay is built when RVVI_REPLAY_TIMEOUT_EN is defined.
module rvvi_replay_list
  import rvvi_pkg::*;
#(
  parameter int DEPTH_LOG2        = 3,
  parameter int WIDTH             = 792,
  parameter int FRAME_COUNT_WIDTH = RVVI_FRAME_COUNT_WIDTH,
  parameter int TIMEOUT_CYCLES    = 4096,
  parameter int MAX_RETRIES       = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         DutValid,
  input  logic [WIDTH-1:0]             DutData,
  input  logic                         HostAckValid,
  input  logic [FRAME_COUNT_WIDTH-1:0] HostFrameCount,
  input  logic                         RVVIStall,
  output logic [WIDTH-1:0]             ActiveListData,
  output logic                         SelActiveList,
  output logic                         ActiveListStall,
  output logic [DEPTH_LOG2:0]          Occupancy,
  output logic                         RetryError,
  output logic                         Overflow
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int RC_W  = $clog2(MAX_RETRIES + 1) + 1;

  logic [WIDTH-1:0]             mem_q [DEPTH];
  logic [FRAME_COUNT_WIDTH-1:0] tag_q [DEPTH];
  logic [DEPTH-1:0]             active_q, active_d;
  logic [DEPTH_LOG2-1:0]        head_q, head_d, tail_q, tail_d;
  logic [DEPTH_LOG2-1:0]        replay_ptr_q, replay_ptr_d;
  logic [DEPTH_LOG2:0]          round_left_q, round_left_d;
  logic [RC_W-1:0]              retry_count_q, retry_count_d;
  rl_state_t                    state_q, state_d;
  logic                         retry_error_q, retry_error_d;
  logic                         overflow_q, overflow_d;

  logic [DEPTH_LOG2:0]   occupancy;
  logic                  full, insert, ack_hit, ack_clear, tail_advance;
  logic [DEPTH_LOG2-1:0] ack_idx;
  logic                  trigger, enter_replay, replay_beat, timeout_fire;

  rvvi_tag_match #(
    .ENTRIES  (DEPTH),
    .TAG_WIDTH(FRAME_COUNT_WIDTH),
    .IDX_WIDTH(DEPTH_LOG2)
  ) u_tag_match (
    .tags  (tag_q),
    .active(active_q),
    .key   (HostFrameCount),
    .hit   (ack_hit),
    .idx   (ack_idx)
  );

  always_comb begin
    occupancy = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occupancy = occupancy + (DEPTH_LOG2 + 1)'(active_q[i]);
    end
  end

  assign full      = (occupancy == (DEPTH_LOG2 + 1)'(DEPTH));
  assign insert    = DutValid & ~full;
  assign ack_clear = HostAckValid & ack_hit;
  // The occupancy term lets the tail walk off an acked slot even when it sits on head after a wrap.
  assign tail_advance = ~active_q[tail_q] & ((tail_q != head_q) | (occupancy != '0));

  always_comb begin
    active_d = active_q;
    if (ack_clear) active_d[ack_idx] = 1'b0;
    if (insert)    active_d[head_q]  = 1'b1;
    head_d     = insert ? head_q + DEPTH_LOG2'(1) : head_q;
    tail_d     = tail_advance ? tail_q + DEPTH_LOG2'(1) : tail_q;
    overflow_d = overflow_q | (DutValid & full);
  end

  assign replay_beat = (state_q == RL_REPLAY) & ~RVVIStall;

  always_comb begin
    state_d       = state_q;
    replay_ptr_d  = replay_ptr_q;
    round_left_d  = round_left_q;
    retry_count_d = retry_count_q;
    retry_error_d = retry_error_q;
    trigger       = 1'b0;
    enter_replay  = 1'b0;
    unique case (state_q)
      RL_IDLE:   trigger = (ack_clear & (ack_idx != tail_q)) | timeout_fire;
      RL_REPLAY: begin
        if (replay_beat) begin
          replay_ptr_d = replay_ptr_q + DEPTH_LOG2'(1);
          if (round_left_q == (DEPTH_LOG2 + 1)'(1)) state_d = RL_WAIT;
          else round_left_d = round_left_q - (DEPTH_LOG2 + 1)'(1);
        end
      end
      RL_WAIT: begin
        if (occupancy == '0) begin
          state_d       = RL_IDLE;
          retry_count_d = '0;
        end else begin
          trigger = timeout_fire;
        end
      end
      default: state_d = RL_IDLE;
    endcase
    // Once the retry budget is spent, triggers are dropped until reset.
    if (trigger && !retry_error_q) begin
      if (retry_count_q == RC_W'(MAX_RETRIES)) begin
        retry_error_d = 1'b1;
        state_d       = RL_IDLE;
      end else begin
        enter_replay  = 1'b1;
        state_d       = RL_REPLAY;
        replay_ptr_d  = tail_q;
        round_left_d  = occupancy;
        retry_count_d = retry_count_q + RC_W'(1);
      end
    end
  end

`ifdef RVVI_REPLAY_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES) + 1;

  logic [TO_W-1:0] timeout_cnt_q, timeout_cnt_d;
  logic            timeout_counting;

  always_comb begin
    timeout_counting = ((state_q == RL_IDLE) | (state_q == RL_WAIT)) & (occupancy != '0);
    timeout_fire     = timeout_counting & (timeout_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
    timeout_cnt_d    = (timeout_counting & ~tail_advance & ~enter_replay & ~timeout_fire)
                     ? timeout_cnt_q + TO_W'(1) : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) timeout_cnt_q <= '0;
    else       timeout_cnt_q <= timeout_cnt_d;
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = |TIMEOUT_CYCLES;
  assign timeout_fire       = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (insert) begin
      mem_q[head_q] <= DutData;
      tag_q[head_q] <= DutData[FRAME_COUNT_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      active_q      <= '0;
      head_q        <= '0;
      tail_q        <= '0;
      replay_ptr_q  <= '0;
      round_left_q  <= '0;
      retry_count_q <= '0;
      state_q       <= RL_IDLE;
      retry_error_q <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      active_q      <= active_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      replay_ptr_q  <= replay_ptr_d;
      round_left_q  <= round_left_d;
      retry_count_q <= retry_count_d;
      state_q       <= state_d;
      retry_error_q <= retry_error_d;
      overflow_q    <= overflow_d;
    end
  end

  assign ActiveListData  = (state_q == RL_REPLAY) ? mem_q[replay_ptr_q] : '0;
  assign SelActiveList   = replay_beat & active_q[replay_ptr_q];
  assign ActiveListStall = (state_q != RL_IDLE) | full;
  assign Occupancy       = occupancy;
  assign RetryError      = retry_error_q;
  assign Overflow        = overflow_q;

endmodule

// File: tb/tb_rvvi_replay_list.sv
// Directed bench for rvvi_replay_list; the timeout scenario runs when RVVI_REPLAY_TIMEOUT_EN is defined.
module tb_rvvi_replay_list;

  localparam int DL  = 3;
  localparam int W   = 64;
  localparam int FCW = 16;

  logic           clk = 1'b0;
  logic           reset;
  logic           DutValid;
  logic [W-1:0]   DutData;
  logic           HostAckValid;
  logic [FCW-1:0] HostFrameCount;
  logic           RVVIStall;
  logic [W-1:0]   ActiveListData;
  logic           SelActiveList;
  logic           ActiveListStall;
  logic [DL:0]    Occupancy;
  logic           RetryError;
  logic           Overflow;

  int          testsRun = 0;
  int          testsFailed = 0;
  logic [15:0] replayTags[$];
  logic        watch = 1'b0;
  logic        seenSel, seenStall;
  int          selCount;

  rvvi_replay_list #(
    .DEPTH_LOG2       (DL),
    .WIDTH            (W),
    .FRAME_COUNT_WIDTH(FCW),
    .TIMEOUT_CYCLES   (16),
    .MAX_RETRIES      (4)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .DutValid       (DutValid),
    .DutData        (DutData),
    .HostAckValid   (HostAckValid),
    .HostFrameCount (HostFrameCount),
    .RVVIStall      (RVVIStall),
    .ActiveListData (ActiveListData),
    .SelActiveList  (SelActiveList),
    .ActiveListStall(ActiveListStall),
    .Occupancy      (Occupancy),
    .RetryError     (RetryError),
    .Overflow       (Overflow)
  );

  always #5 clk = ~clk;

  // Sticky observers used to prove that something never happened over a window.
  always @(negedge clk) begin
    if (watch) begin
      seenSel   = seenSel | SelActiveList;
      seenStall = seenStall | ActiveListStall;
    end else begin
      seenSel   = 1'b0;
      seenStall = 1'b0;
    end
  end

  function automatic logic [W-1:0] frameOf(input logic [15:0] t);
    return {16'hC0DE, ~t, 16'hBEEF, t};
  endfunction

  task automatic stepClk();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [15:0] dTag,
                               input logic ackValid, input logic [15:0] ackTag);
    DutValid       = valid;
    DutData        = frameOf(dTag);
    HostAckValid   = ackValid;
    HostFrameCount = ackTag;
    stepClk();
    DutValid     = 1'b0;
    HostAckValid = 1'b0;
  endtask

  task automatic insertFrame(input logic [15:0] t);
    applyStimulus(1'b1, t, 1'b0, 16'h0);
  endtask

  task automatic ackFrame(input logic [15:0] t);
    applyStimulus(1'b0, 16'h0, 1'b1, t);
  endtask

  // One idle cycle after each ack gives the tail time to step past the retired slot.
  task automatic ackGap(input logic [15:0] t);
    ackFrame(t);
    stepClk();
  endtask

  task automatic doReset();
    reset = 1'b1;
    stepClk();
    stepClk();
    reset = 1'b0;
  endtask

  task automatic collectReplay(input int cycles);
    replayTags.delete();
    for (int c = 0; c < cycles; c++) begin
      if (SelActiveList) replayTags.push_back(ActiveListData[15:0]);
      stepClk();
    end
  endtask

  task automatic checkReplay(input string name, input logic [15:0] exp [], input int n);
    checkOutput({name, "_count"}, 64'(replayTags.size()), 64'(n));
    for (int i = 0; i < n; i++) begin
      checkOutput($sformatf("%s_beat%0d", name, i),
                  (i < replayTags.size()) ? 64'(replayTags[i]) : 64'hDEAD, 64'(exp[i]));
    end
  endtask

  initial begin
    logic [15:0] exp2 [] = '{16'd0, 16'd1, 16'd3, 16'd4};
    logic [15:0] exp3 [] = '{16'd10, 16'd11, 16'd12, 16'd13, 16'd14, 16'd16, 16'd17};

    DutValid = 1'b0;
    DutData = '0;
    HostAckValid = 1'b0;
    HostFrameCount = '0;
    RVVIStall = 1'b0;
    doReset();

    checkOutput("reset_stall", ActiveListStall, 0);
    checkOutput("reset_sel", SelActiveList, 0);
    checkOutput("reset_occ", Occupancy, 0);
    checkOutput("reset_data", ActiveListData, 0);
    checkOutput("reset_overflow", Overflow, 0);
    checkOutput("reset_retryerr", RetryError, 0);

    $display("[TB] in-order acks");
    watch = 1'b1;
    for (int t = 0; t < 4; t++) insertFrame(16'(t));
    checkOutput("inorder_occ4", Occupancy, 4);
    for (int t = 0; t < 4; t++) ackGap(16'(t));
    watch = 1'b0;
    checkOutput("inorder_occ0", Occupancy, 0);
    checkOutput("inorder_no_sel", seenSel, 0);
    checkOutput("inorder_no_stall", seenStall, 0);

    $display("[TB] out-of-order ack");
    doReset();
    for (int t = 0; t < 5; t++) insertFrame(16'(t));
    ackFrame(16'd2);
    checkOutput("ooo_first_sel", SelActiveList, 1);
    checkOutput("ooo_first_frame", ActiveListData, frameOf(16'd0));
    checkOutput("ooo_stall_replay", ActiveListStall, 1);
    collectReplay(8);
    checkReplay("ooo", exp2, 4);
    checkOutput("ooo_wait_stall", ActiveListStall, 1);
    checkOutput("ooo_wait_occ", Occupancy, 4);
`ifndef RVVI_REPLAY_TIMEOUT_EN
    watch = 1'b1;
    repeat (40) stepClk();
    watch = 1'b0;
    checkOutput("ooo_no_spontaneous_replay", seenSel, 0);
`endif
    ackGap(16'd0);
    ackGap(16'd1);
    ackGap(16'd3);
    ackGap(16'd4);
    stepClk();
    checkOutput("ooo_idle_stall", ActiveListStall, 0);
    checkOutput("ooo_occ0", Occupancy, 0);
    checkOutput("ooo_retrycount", dut.retry_count_q, 0);

    $display("[TB] full and overflow");
    doReset();
    for (int t = 10; t < 18; t++) insertFrame(16'(t));
    checkOutput("full_occ8", Occupancy, 8);
    checkOutput("full_stall", ActiveListStall, 1);
    checkOutput("full_no_overflow", Overflow, 0);
    insertFrame(16'd99);
    checkOutput("full_overflow", Overflow, 1);
    checkOutput("full_head_held", dut.head_q, 0);
    checkOutput("full_occ_held", Occupancy, 8);
    ackFrame(16'd15);
    collectReplay(10);
    checkReplay("full", exp3, 7);
    for (int t = 10; t < 18; t++) if (t != 15) ackGap(16'(t));
    stepClk();
    checkOutput("full_drained_occ", Occupancy, 0);
    checkOutput("full_drained_stall", ActiveListStall, 0);
    checkOutput("full_overflow_sticky", Overflow, 1);

    $display("[TB] stall during replay");
    doReset();
    for (int t = 0; t < 5; t++) insertFrame(16'(t));
    ackFrame(16'd2);
    checkOutput("stall_beat0_sel", SelActiveList, 1);
    checkOutput("stall_beat0_tag", ActiveListData[15:0], 0);
    stepClk();
    RVVIStall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      checkOutput($sformatf("stall_held_sel%0d", k), SelActiveList, 0);
      checkOutput($sformatf("stall_frozen_tag%0d", k), ActiveListData[15:0], 1);
      stepClk();
    end
    RVVIStall = 1'b0;
    #1;
    checkOutput("stall_resume_sel", SelActiveList, 1);
    checkOutput("stall_resume_tag", ActiveListData[15:0], 1);
    stepClk();
    checkOutput("stall_skip_acked", SelActiveList, 0);
    stepClk();
    checkOutput("stall_tag3", ActiveListData[15:0], 3);
    checkOutput("stall_tag3_sel", SelActiveList, 1);
    stepClk();
    checkOutput("stall_tag4", ActiveListData[15:0], 4);
    stepClk();
    checkOutput("stall_wait_sel", SelActiveList, 0);
    checkOutput("stall_wait_stall", ActiveListStall, 1);
    ackGap(16'd0);
    ackGap(16'd1);
    ackGap(16'd3);
    ackGap(16'd4);
    stepClk();
    checkOutput("stall_idle", ActiveListStall, 0);

    $display("[TB] reset during replay");
    doReset();
    for (int t = 0; t < 5; t++) insertFrame(16'(t));
    ackFrame(16'd2);
    stepClk();
    checkOutput("rst_in_replay", ActiveListStall, 1);
    reset = 1'b1;
    stepClk();
    reset = 1'b0;
    checkOutput("rst_stall", ActiveListStall, 0);
    checkOutput("rst_sel", SelActiveList, 0);
    checkOutput("rst_occ", Occupancy, 0);
    checkOutput("rst_data", ActiveListData, 0);

`ifdef RVVI_REPLAY_TIMEOUT_EN
    $display("[TB] timeout replay and retry limit");
    doReset();
    insertFrame(16'h42);
    watch = 1'b1;
    repeat (15) stepClk();
    watch = 1'b0;
    checkOutput("to_no_early_replay", seenSel, 0);
    stepClk();
    checkOutput("to_first_sel", SelActiveList, 1);
    checkOutput("to_first_tag", ActiveListData[15:0], 16'h42);
    selCount = 1;
    repeat (64) begin
      stepClk();
      if (SelActiveList) selCount++;
    end
    checkOutput("to_no_error_yet", RetryError, 0);
    repeat (16) begin
      stepClk();
      if (SelActiveList) selCount++;
    end
    checkOutput("to_replay_rounds", 64'(selCount), 4);
    checkOutput("to_retry_error", RetryError, 1);
    checkOutput("to_error_idle", ActiveListStall, 0);
    checkOutput("to_error_occ", Occupancy, 1);
`endif

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
